// File: rtl/ram_pkg.sv
// ram_pkg: shared geometry, FIFO sizing and FSM encoding for the RAM point reader.
package ram_pkg;
    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 1024;
    localparam int PT_BITS    = 10;
    localparam int LENGTH     = 16;
    localparam int LEN_BITS   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS   = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/feat_fifo.sv
// feat_fifo: 4-entry synchronous first-word fall-through buffer of {last, idx, data}.
module feat_fifo
    import ram_pkg::*;
#(
    parameter int W = DATA_WIDTH + LEN_BITS + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [W-1:0]        din,
    input  logic                pop,
    output logic [W-1:0]        dout,
    output logic                valid,
    output logic [CNT_BITS-1:0] count
);
    logic [W-1:0]        mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;
    assign valid   = count != '0;
    assign do_pop  = pop && valid;
    assign do_push = push && (count != CNT_BITS'(FIFO_DEPTH) || do_pop);
    // Empty head reads as zero so nothing stale is visible after reset or drain.
    assign dout    = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
        end
    end
endmodule

// File: rtl/ram_point_reader.sv
// ram_point_reader: fetches the LENGTH features of one data point from a
// two-stage synchronous RAM and streams them out through a small FWFT buffer.
module ram_point_reader #(
    parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
    parameter int DEPTH      = ram_pkg::DEPTH,
    parameter int PT_BITS    = ram_pkg::PT_BITS,
    parameter int LENGTH     = ram_pkg::LENGTH,
    parameter int LEN_BITS   = ram_pkg::LEN_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PT_BITS-1:0]    point_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_cs,
    output logic                  ram_oe,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  feat_valid,
    input  logic                  feat_ready,
    output logic [DATA_WIDTH-1:0] feat_data,
    output logic [LEN_BITS-1:0]   feat_idx,
    output logic                  feat_last
);
    import ram_pkg::*;
    if (PT_BITS + LEN_BITS != ADDR_WIDTH || DEPTH > (1 << PT_BITS) || LENGTH > (1 << LEN_BITS)) begin : g_geom_err
        $error("ram_point_reader: inconsistent address geometry");
    end
    localparam logic [LEN_BITS-1:0] LAST_IDX = LEN_BITS'(LENGTH - 1);
    state_t                state;
    state_t                state_nx;
    logic [PT_BITS-1:0]    pt;
    logic [LEN_BITS-1:0]   feat_cnt;
    logic [LEN_BITS-1:0]   idx1;
    logic [LEN_BITS-1:0]   idx2;
    logic                  v1;
    logic                  v2;
    logic [CNT_BITS-1:0]   fifo_cnt;
    logic                  accept;
    logic                  issue;
    logic                  issue_last;
    logic                  cap_last;
    logic                  pop;
    logic                  last_pop;
    // v1/v2 track the two RAM stages; together they are the in-flight count.
    assign accept     = state == IDLE && start;
    assign issue      = state == FETCH && (fifo_cnt + CNT_BITS'(v1) + CNT_BITS'(v2)) < CNT_BITS'(FIFO_DEPTH);
    assign issue_last = issue && feat_cnt == LAST_IDX;
    assign cap_last   = v2 && idx2 == LAST_IDX;
    assign pop        = feat_valid && feat_ready;
    assign last_pop   = state == DRAIN && pop && feat_last && fifo_cnt == CNT_BITS'(1) && !v1 && !v2;
    assign busy       = state != IDLE;
    assign ram_oe     = ram_cs;
    assign ram_we     = 1'b0;
    always_comb begin
        state_nx = state;
        state_nx = accept ? FETCH : issue_last ? DRAIN : last_pop ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt       <= '0;
            feat_cnt <= '0;
            idx1     <= '0;
            idx2     <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            ram_addr <= '0;
            ram_cs   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_pop;
            v1   <= issue;
            idx1 <= feat_cnt;
            v2   <= v1;
            idx2 <= idx1;
            if (accept) begin
                pt       <= point_idx;
                feat_cnt <= '0;
            end else if (issue && !issue_last) begin
                feat_cnt <= feat_cnt + 1'b1;
            end
            if (issue) ram_addr <= ADDR_WIDTH'({pt, feat_cnt});
            // Select stays up through stalls until the last word is captured.
            ram_cs <= issue || (ram_cs && !cap_last);
        end
    end
    feat_fifo #(
        .W(DATA_WIDTH + LEN_BITS + 1)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (v2),
        .din  ({cap_last, idx2, ram_rdata}),
        .pop  (pop),
        .dout ({feat_last, feat_idx, feat_data}),
        .valid(feat_valid),
        .count(fifo_cnt)
    );
endmodule

// File: tb/tb_ram_point_reader.sv
// tb_ram_point_reader: directed checks of fetch order, latency, stalls, busy starts and reset abort.
module tb_ram_point_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  point_idx;
    logic        busy;
    logic        done;
    logic        ram_cs;
    logic        ram_oe;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [31:0] rdata;
    logic        feat_valid;
    logic        feat_ready;
    logic [31:0] feat_data;
    logic [3:0]  feat_idx;
    logic        feat_last;
    logic [31:0] mem [16384];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [36:0] beats[$];
    int          beat_edge[$];
    logic [13:0] addrs[$];
    logic [13:0] prev_addr = '0;
    logic [36:0] prev_word = '0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    int          first_valid;
    int          done_cnt;
    int          done_edge;
    int          valid_cnt;
    ram_point_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .point_idx (point_idx),
        .busy      (busy),
        .done      (done),
        .ram_cs    (ram_cs),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_rdata (rdata),
        .feat_valid(feat_valid),
        .feat_ready(feat_ready),
        .feat_data (feat_data),
        .feat_idx  (feat_idx),
        .feat_last (feat_last)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Two-stage RAM: address sampled on the edge, word visible until the next read.
    always @(posedge clk) begin
        if (ram_cs && ram_oe && !ram_we) rdata <= mem[ram_addr];
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] outs();
        return 64'({busy, done, feat_valid, feat_last, ram_cs, ram_oe, ram_we, ram_addr, feat_data, feat_idx});
    endfunction
    function automatic logic [31:0] fdata(input int p, input int k);
        return (32'(p) << 24) + 32'(k);
    endfunction
    always @(negedge clk) begin
        logic [36:0] cur;
        cur = {feat_last, feat_idx, feat_data};
        if (prev_valid && !prev_ready) begin
            check("stall_valid", 64'(feat_valid), 64'(1));
            check("stall_hold", 64'(cur), 64'(prev_word));
        end
        if (busy) check("outstanding_le4", 64'((addrs.size() - beats.size()) <= 4), 64'(1));
        if (ram_addr != prev_addr) addrs.push_back(ram_addr);
        if (feat_valid && feat_ready) begin
            beats.push_back(cur);
            beat_edge.push_back(cyc + 1);
        end
        if (feat_valid && first_valid < 0) first_valid = cyc;
        if (feat_valid) valid_cnt++;
        if (done) begin
            done_cnt++;
            done_edge = cyc;
        end
        prev_addr  = ram_addr;
        prev_word  = cur;
        prev_valid = feat_valid;
        prev_ready = feat_ready;
    end
    // mode 0: ready high, 1: ready toggling, 2: ready low for 20 cycles.
    task automatic run_fetch(input int p, input int mode, input bit inject, input int abort_idx);
        int  n;
        int  start_edge;
        bit  aborted;
        beats.delete();
        beat_edge.delete();
        addrs.delete();
        first_valid = -1;
        done_cnt    = 0;
        aborted     = 0;
        feat_ready  = (mode != 2);
        point_idx   = 10'(p);
        start       = 1'b1;
        start_edge  = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        n = 0;
        while (n < 400 && !done) begin
            if (abort_idx >= 0 && feat_valid && feat_idx == 4'(abort_idx)) begin
                rst_n = 1'b0;
                #1;
                check("reset_outputs_zero", outs(), 64'(0));
                aborted = 1;
                break;
            end
            feat_ready = mode == 0 ? 1'b1 : mode == 1 ? (n % 2 == 0) : (n >= 20);
            if (mode == 2 && n == 20) begin
                check("stall_issues", 64'(addrs.size()), 64'(4));
                check("stall_cs_oe", 64'({ram_cs, ram_oe}), 64'(2'b11));
                check("stall_valid_held", 64'(feat_valid), 64'(1));
            end
            start = inject && n == 4;
            if (start) point_idx = 10'd9;
            @(posedge clk);
            #1;
            n++;
        end
        if (aborted) begin
            valid_cnt = 0;
            repeat (3) @(negedge clk);
            #1;
            rst_n = 1'b1;
            repeat (6) @(negedge clk);
            #1;
            check("abort_no_done", 64'(done_cnt), 64'(0));
            check("abort_no_stale", 64'(valid_cnt), 64'(0));
            return;
        end
        check("timeout", 64'(n < 400), 64'(1));
        @(negedge clk);
        #1;
        check("beat_count", 64'(beats.size()), 64'(16));
        check("addr_count", 64'(addrs.size()), 64'(16));
        for (int k = 0; k < 16; k++) begin
            if (k < beats.size()) check("beat", 64'(beats[k]), 64'({k == 15, 4'(k), fdata(p, k)}));
            if (k < addrs.size()) check("addr", 64'(addrs[k]), 64'({10'(p), 4'(k)}));
        end
        check("first_valid_lat", 64'(first_valid - start_edge), 64'(3));
        check("done_count", 64'(done_cnt), 64'(1));
        if (beat_edge.size() > 0) check("done_edge", 64'(done_edge), 64'(beat_edge[$]));
        check("busy_low_at_done", 64'(busy), 64'(0));
    endtask
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        point_idx  = '0;
        feat_ready = 1'b0;
        rdata      = '0;
        for (int a = 0; a < 16384; a++) mem[a] = fdata(a >> 4, a & 15);
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 64'(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        run_fetch(5, 0, 0, -1);
        run_fetch(5, 1, 0, -1);
        run_fetch(5, 2, 0, -1);
        run_fetch(5, 0, 1, -1);
        run_fetch(1023, 0, 0, -1);
        run_fetch(5, 0, 0, 7);
        run_fetch(2, 0, 0, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_point_reader.md
RAM_POINT_READER -- requirements
Module: ram_point_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, total RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, feature word width.
REQ-003 SHALL have parameters DEPTH, default 1024, data points, and PT_BITS, default 10, point-index width.
REQ-004 SHALL have parameters LENGTH, default 16, features per point, and LEN_BITS, default 4, feature-index width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports are clk and rst_n.
REQ-006 clk  input  1  rising-edge clock, shared with the RAM.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  request a fetch of one data point; sampled only in IDLE.
REQ-009 point_idx  input  PT_BITS  point to fetch; sampled with start.
REQ-010 busy  output  1  high from the start-accepting edge until done.
REQ-011 done  output  1  one-cycle pulse after the last feature handshake.
REQ-012 ram_cs, ram_oe, ram_we  output  1 each  RAM controls; ram_we is constant 0.
REQ-013 ram_addr  output  ADDR_WIDTH  {point, feature}; point in upper PT_BITS, feature in lower LEN_BITS.
REQ-014 ram_rdata  input  DATA_WIDTH  RAM data bus; the top level ties it to the RAM inout.
REQ-015 feat_valid, feat_ready  output/input  1 each  stream handshake; transfer occurs when both are high on a rising edge.
REQ-016 feat_data  output  DATA_WIDTH  feature word.
REQ-017 feat_idx  output  LEN_BITS  feature number, 0..LENGTH-1.
REQ-018 feat_last  output  1  high with feat_idx = LENGTH-1.

Function
REQ-019 FSM states SHALL be IDLE, FETCH and DRAIN.
- IDLE->FETCH on start.
- FETCH->DRAIN after feature LENGTH-1 is issued.
- DRAIN->IDLE when the FIFO is empty, nothing is in flight, and the last handshake is complete.
REQ-020 start SHALL be ignored while busy; point_idx SHALL be latched on the accepting edge.
REQ-021 RAM read timing SHALL be modelled as two stages:
- address registered at edge E is sampled by the RAM at E+1;
- the reader captures ram_rdata into the FIFO at E+2.
REQ-022 In flight SHALL mean issued but not yet captured; the in-flight count is 0..2.
REQ-023 A feature read SHALL be issued only when FIFO occupancy plus in-flight count is below 4, so no data is ever lost.
REQ-024 ram_cs and ram_oe SHALL be high from the first issue until the last capture, and low otherwise.
REQ-025 ram_addr SHALL hold its last value when no read is issued; re-reading the same address is harmless.
REQ-026 Features SHALL be issued and delivered in order 0..LENGTH-1, each exactly once.
REQ-027 With feat_ready held high, the first feat_valid SHALL occur 3 edges after the accepting edge, then one feature per cycle.
REQ-028 While feat_valid is high and feat_ready is low, feat_data, feat_idx and feat_last SHALL remain stable.
REQ-029 done SHALL pulse on the edge after the final handshake.
- busy SHALL fall at that same edge.
- A start on the following cycle SHALL be accepted.
REQ-030 The feature counter SHALL wrap from LENGTH-1 only by returning to IDLE; point_idx = DEPTH-1 is legal.

Reset
REQ-031 On rst_n low, the following SHALL clear immediately:
- state = IDLE;
- busy, done, feat_valid, feat_last, ram_cs, ram_oe, ram_we = 0;
- ram_addr, feat_data, feat_idx = 0;
- FIFO and in-flight count emptied.
REQ-032 Reset mid-fetch SHALL abandon the point; no done pulse is produced and no stale feature appears after release.
REQ-033 Release SHALL be synchronised by the instantiating top level; the block requires none internally.

Structure
REQ-034 ADDR_WIDTH, DATA_WIDTH, DEPTH, LENGTH, LEN_BITS, PT_BITS and the state encoding SHALL live in shared package ram_pkg.
REQ-035 The 4-entry output buffer SHALL be sub-module feat_fifo.
- Synchronous, first-word fall-through.
- Stores {last, idx, data}.
- Exposes a count output.

Verification
REQ-036 Bench SHALL load RAM point 5 features with 0x0500_0000+k, then start with point_idx=5 and feat_ready=1.
- Expect 16 beats, data 0x0500_0000..0x0500_000F in order.
- First beat 3 edges after start; feat_last only on idx 15; done 1 cycle after the last beat.
REQ-037 Bench SHALL repeat with feat_ready toggling 1/0 each cycle.
- Expect the identical sequence with data stable during stalls.
- Expect no ram_addr issue while FIFO plus in-flight count equals 4.
REQ-038 Bench SHALL hold feat_ready=0 for 20 cycles after start.
- Expect exactly 4 reads issued, then cs/oe held and FIFO full.
- On release, expect all 16 features delivered.
REQ-039 Bench SHALL pulse start with point_idx=9 while busy on point 5.
- Expect it ignored: only point 5 is delivered.
- A start with point_idx=1023 in the cycle after done SHALL fetch addresses 0x3FF0..0x3FFF.
REQ-040 Bench SHALL assert rst_n=0 at feature 7 of a fetch.
- Expect all outputs zero within the same cycle and no done pulse.
- A new start with point_idx=2 after release SHALL deliver features from 0 cleanly.
